// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM stage register with valid/ready handshake,
// optional 2-entry skid buffer, synchronous flush and EX forwarding tap.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   flush_i          drop every held entry (redirect)
//   up_*             EX side: valid/ready plus payload and GPR write fields
//   dn_*             MEM side: head entry valid/ready plus its fields
//   fwd_*            combinational EX-result tap for hazard logic
//   occupancy_o      number of held entries (0..2), registered
module ex_mem_pipe #(
  parameter int PAYLOAD_W = 128,
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 up_valid_i,
  output logic                 up_ready_o,
  input  logic [PAYLOAD_W-1:0] up_payload_i,
  input  logic                 up_reg_we_i,
  input  logic [REG_AW-1:0]    up_reg_waddr_i,
  input  logic [DATA_W-1:0]    up_reg_wdata_i,
  output logic                 dn_valid_o,
  input  logic                 dn_ready_i,
  output logic [PAYLOAD_W-1:0] dn_payload_o,
  output logic                 dn_reg_we_o,
  output logic [REG_AW-1:0]    dn_reg_waddr_o,
  output logic [DATA_W-1:0]    dn_reg_wdata_o,
  output logic                 fwd_we_o,
  output logic [REG_AW-1:0]    fwd_addr_o,
  output logic [DATA_W-1:0]    fwd_data_o,
  output logic [1:0]           occupancy_o
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 we;
    logic [REG_AW-1:0]    waddr;
    logic [DATA_W-1:0]    wdata;
  } ent_t;

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  ent_t   head_q, head_d;
  ent_t   skid_q, skid_d;
  ent_t   in_ent;
  logic   push, pop;

  assign in_ent = {up_payload_i, up_reg_we_i,
                   up_reg_waddr_i, up_reg_wdata_i};

  assign dn_valid_o = (state_q != EMPTY);

  // Skid mode: ready decodes registered state only, so
  // dn_ready_i never reaches up_ready_o combinationally.
  generate
    if (SKID_EN) begin : g_skid
      assign up_ready_o = (state_q != TWO);
    end else begin : g_flat
      assign up_ready_o = ~dn_valid_o | dn_ready_i;
    end
  endgenerate

  assign push = up_valid_i & up_ready_o;
  assign pop  = dn_valid_o & dn_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_ent;
          end
        end
        ONE: begin
          unique case (1'b1)
            push && pop: head_d = in_ent;
            push && !pop: begin
              state_d = TWO;
              skid_d  = in_ent;
            end
            !push && pop: begin
              state_d = EMPTY;
              head_d  = '0;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign dn_payload_o   = head_q.payload;
  assign dn_reg_we_o    = head_q.we;
  assign dn_reg_waddr_o = head_q.waddr;
  assign dn_reg_wdata_o = head_q.wdata;
  assign occupancy_o    = state_q;

  // x0 writes are never forwarded; a redirect kills the tap.
  assign fwd_we_o   = ~flush_i & up_valid_i & up_reg_we_i
                    & (|up_reg_waddr_i);
  assign fwd_addr_o = flush_i ? '0 : up_reg_waddr_i;
  assign fwd_data_o = flush_i ? '0 : up_reg_wdata_i;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: checks ex_mem_pipe in skid and flat modes
// against a queue-based reference model.
module tb_ex_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush;

  logic         a_valid, a_we, a_dnr;
  logic [127:0] a_pl;
  logic [4:0]   a_addr;
  logic [31:0]  a_data;
  logic         a_rdy, a_dv, a_dwe, a_fwe;
  logic [127:0] a_dpl;
  logic [4:0]   a_dad, a_fad;
  logic [31:0]  a_dd, a_fd;
  logic [1:0]   a_occ;

  logic         b_valid, b_we, b_dnr;
  logic [127:0] b_pl;
  logic [4:0]   b_addr;
  logic [31:0]  b_data;
  logic         b_rdy, b_dv, b_dwe, b_fwe;
  logic [127:0] b_dpl;
  logic [4:0]   b_dad, b_fad;
  logic [31:0]  b_dd, b_fd;
  logic [1:0]   b_occ;

  ex_mem_pipe #(.SKID_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .up_valid_i(a_valid), .up_ready_o(a_rdy),
    .up_payload_i(a_pl), .up_reg_we_i(a_we),
    .up_reg_waddr_i(a_addr), .up_reg_wdata_i(a_data),
    .dn_valid_o(a_dv), .dn_ready_i(a_dnr),
    .dn_payload_o(a_dpl), .dn_reg_we_o(a_dwe),
    .dn_reg_waddr_o(a_dad), .dn_reg_wdata_o(a_dd),
    .fwd_we_o(a_fwe), .fwd_addr_o(a_fad), .fwd_data_o(a_fd),
    .occupancy_o(a_occ)
  );

  ex_mem_pipe #(.SKID_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .up_valid_i(b_valid), .up_ready_o(b_rdy),
    .up_payload_i(b_pl), .up_reg_we_i(b_we),
    .up_reg_waddr_i(b_addr), .up_reg_wdata_i(b_data),
    .dn_valid_o(b_dv), .dn_ready_i(b_dnr),
    .dn_payload_o(b_dpl), .dn_reg_we_o(b_dwe),
    .dn_reg_waddr_o(b_dad), .dn_reg_wdata_o(b_dd),
    .fwd_we_o(b_fwe), .fwd_addr_o(b_fad), .fwd_data_o(b_fd),
    .occupancy_o(b_occ)
  );

  typedef struct packed {
    logic [127:0] p;
    logic         we;
    logic [4:0]   a;
    logic [31:0]  d;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  bit   known = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drv_a(bit v, logic [31:0] d, logic [4:0] ad,
                       bit we, bit r);
    a_valid = v; a_data = d; a_addr = ad; a_we = we;
    a_dnr = r; a_pl = {d, ~d, d ^ 32'h5a5a5a5a, d + 32'd1};
  endtask

  task automatic drv_b(bit v, logic [31:0] d, logic [4:0] ad,
                       bit we, bit r);
    b_valid = v; b_data = d; b_addr = ad; b_we = we;
    b_dnr = r; b_pl = {~d, d, d + 32'd7, d ^ 32'hffff0000};
  endtask

  // One cycle: check the current outputs against the model,
  // then advance the model by the transfers of this edge.
  task automatic step();
    ent_t h;
    bit   ra, rb, pa, pb;
    #1;
    ra = (qa.size() < 2);
    rb = (qb.size() == 0) || b_dnr;
    if (known) begin
      h = (qa.size() > 0) ? qa[0] : '0;
      chk("a_dn_valid", a_dv, qa.size() > 0);
      chk("a_dn_payload", a_dpl, h.p);
      chk("a_dn_we", a_dwe, h.we);
      chk("a_dn_waddr", a_dad, h.a);
      chk("a_dn_wdata", a_dd, h.d);
      chk("a_occupancy", a_occ, qa.size());
      chk("a_up_ready", a_rdy, ra);
      h = (qb.size() > 0) ? qb[0] : '0;
      chk("b_dn_valid", b_dv, qb.size() > 0);
      chk("b_dn_payload", b_dpl, h.p);
      chk("b_dn_we", b_dwe, h.we);
      chk("b_dn_waddr", b_dad, h.a);
      chk("b_dn_wdata", b_dd, h.d);
      chk("b_occupancy", b_occ, qb.size());
      chk("b_up_ready", b_rdy, rb);
    end
    chk("a_fwd_we", a_fwe,
        a_valid && a_we && a_addr != 0 && !flush);
    chk("a_fwd_addr", a_fad, flush ? 5'd0 : a_addr);
    chk("a_fwd_data", a_fd, flush ? 32'd0 : a_data);
    chk("b_fwd_we", b_fwe,
        b_valid && b_we && b_addr != 0 && !flush);
    if (!rst_n || flush) begin
      qa.delete();
      qb.delete();
      if (!rst_n) known = 1'b1;
    end else begin
      pa = a_valid && ra;
      pb = b_valid && rb;
      if (qa.size() > 0 && a_dnr) void'(qa.pop_front());
      if (qb.size() > 0 && b_dnr) void'(qb.pop_front());
      if (pa) qa.push_back('{a_pl, a_we, a_addr, a_data});
      if (pb) qb.push_back('{b_pl, b_we, b_addr, b_data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // reset held two cycles, then idle
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    // streaming through the skid stage
    drv_a(1, 32'h11, 5'd1, 1, 1); step();
    drv_a(1, 32'h22, 5'd2, 1, 1); step();
    drv_a(1, 32'h33, 5'd3, 1, 1); step();
    drv_a(0, 0, 0, 0, 1); step();
    step();

    // backpressure fills both entries
    drv_a(1, 32'hA, 5'd4, 1, 0); step();
    drv_a(1, 32'hB, 5'd6, 0, 0); step();
    drv_a(1, 32'hE, 5'd7, 1, 0); step();
    drv_a(0, 0, 0, 0, 1); step();
    step();
    step();

    // flush while full, with a live input in the flush cycle
    drv_a(1, 32'h1, 5'd8, 1, 0); step();
    drv_a(1, 32'h2, 5'd9, 1, 0); step();
    flush = 1'b1;
    drv_a(1, 32'hC, 5'd10, 1, 1); step();
    flush = 1'b0;
    drv_a(0, 0, 0, 0, 1); step();
    step();

    // forwarding tap
    drv_a(1, 32'hDEAD, 5'd5, 1, 0); step();
    drv_a(1, 32'hBEEF, 5'd0, 1, 1); step();
    flush = 1'b1;
    drv_a(1, 32'hCAFE, 5'd5, 1, 1); step();
    flush = 1'b0;
    drv_a(0, 0, 0, 0, 1); step();

    // flat stage: stall, then release with a new push
    drv_b(1, 32'h77, 5'd3, 1, 0); step();
    drv_b(1, 32'h88, 5'd4, 1, 0); step();
    step();
    drv_b(1, 32'h88, 5'd4, 1, 1); step();
    drv_b(0, 0, 0, 0, 1); step();
    step();

    // random traffic on both stages
    for (int i = 0; i < 600; i++) begin
      flush = ($urandom_range(0, 24) == 0);
      drv_a($urandom_range(0, 3) != 0, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom),
            $urandom_range(0, 2) != 0);
      drv_b($urandom_range(0, 3) != 0, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom),
            $urandom_range(0, 2) != 0);
      step();
    end
    flush = 1'b0;
    drv_a(0, 0, 0, 0, 1);
    drv_b(0, 0, 0, 0, 1);
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
